spr_rom_arbiter: RTL and testbench
==================================

SPR_ROM_ARBITER -- requirements
Module: spr_rom_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 19, sprite ROM word address width.
REQ-002 The block SHALL have parameter FAIR_MAX, default 4, the number of consecutive renderer grants allowed while a CPU request waits.
REQ-003 clk_main  in  1  single clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 rnd_req  in  1  renderer fetch strobe, one cycle.
REQ-006 rnd_addr  in  AW  renderer word address, sampled with rnd_req.
REQ-007 rnd_valid  out  1  one-cycle strobe: rnd_data is valid.
REQ-008 rnd_data  out  32  renderer read data, held until the next rnd_valid.
REQ-009 cpu_req  in  1  CPU ROM-readback fetch strobe, one cycle.
REQ-010 cpu_addr  in  AW  CPU word address, sampled with cpu_req.
REQ-011 cpu_valid  out  1  one-cycle strobe: cpu_data is valid.
REQ-012 cpu_data  out  32  CPU read data, held until the next cpu_valid.
REQ-013 mem_req  out  1  memory request, level; held until mem_ack.
REQ-014 mem_addr  out  AW  memory address, stable while mem_req=1.
REQ-015 mem_ack  in  1  one-cycle acknowledge; mem_dout is valid in the same cycle.
REQ-016 mem_dout  in  32  memory read data.
REQ-017 overrun  out  1  sticky flag: a pending renderer request was overwritten.

Function
REQ-018 The block SHALL hold one pending slot per requester (address plus pend bit), set on its req strobe.
REQ-019 If rnd_req arrives while the renderer slot is already pending and not yet granted, the new address SHALL replace the old one and overrun SHALL set.
REQ-020 If cpu_req arrives while the CPU slot is pending, the new address SHALL replace the old one; overrun SHALL NOT be affected.
REQ-021 The FSM states SHALL be IDLE, ISSUE and DONE.
- IDLE -> ISSUE when any slot is pending and not satisfied by the cache.
- ISSUE -> DONE on mem_ack.
- DONE -> IDLE after one cycle.
REQ-022 Arbitration in IDLE: the renderer wins unless the CPU is pending and fair_cnt = FAIR_MAX, in which case the CPU wins.
REQ-023 fair_cnt SHALL:
- increment on each renderer grant while the CPU is pending, saturating at FAIR_MAX;
- clear on each CPU grant;
- clear whenever the CPU is not pending.
REQ-024 On a grant, the granted slot's pend bit SHALL clear; mem_req and mem_addr SHALL be registered and assert on the cycle after the grant.
REQ-025 A req strobe landing in the same cycle as its slot's grant SHALL set the slot pending again with the new address; this is not an overrun.
REQ-026 On mem_ack, mem_dout SHALL be captured and mem_req SHALL drop in the next cycle.
REQ-027 In DONE, the owner's valid SHALL pulse for exactly one cycle, with the owner's data register updated in that cycle.
REQ-028 Latency, uncached: rnd_req at cycle N with IDLE and no contention gives mem_req at N+2 and rnd_valid one cycle after mem_ack.
REQ-029 rnd_valid and cpu_valid SHALL never assert in the same cycle.
REQ-030 mem_req SHALL never drop before mem_ack.
REQ-031 mem_addr SHALL never change while mem_req=1.

Reset
REQ-032 While reset=1:
- state=IDLE; mem_req=0, mem_addr=0;
- rnd_valid=0, cpu_valid=0, rnd_data=0, cpu_data=0;
- pend bits=0, fair_cnt=0, overrun=0, cache invalid.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction: no valid pulse, and a late mem_ack after release SHALL be ignored in IDLE.
REQ-034 overrun SHALL clear only on reset.

Configuration
REQ-035 Macro SPR_ROM_CACHE_EN, when defined, SHALL add a one-entry renderer cache (tag = address of the last renderer fill plus a valid bit).
REQ-036 With SPR_ROM_CACHE_EN defined:
- a pending renderer address equal to a valid tag SHALL be answered from the cache in IDLE;
- rnd_valid SHALL pulse 2 cycles after rnd_req, with no mem_req;
- a hit SHALL count as a renderer grant for fair_cnt;
- a renderer fill SHALL update the tag and data; CPU fills SHALL NOT.
REQ-037 Without SPR_ROM_CACHE_EN, every request SHALL go to memory, and no cache registers SHALL exist.

Verification
REQ-038 Single fetch: rnd_req with addr 0x12345, memory acks 3 cycles after mem_req with 0xDEADBEEF -> mem_addr=0x12345, one rnd_valid with rnd_data=0xDEADBEEF, no cpu_valid.
REQ-039 Fairness, FAIR_MAX=4, CPU pending, rnd_req on every grant -> exactly 4 renderer grants, then 1 CPU grant, then fair_cnt=0.
REQ-040 Overrun: two rnd_req (0x10 then 0x20) while memory services a CPU fetch -> only 0x20 is fetched, overrun=1.
REQ-041 Reset mid-ISSUE with mem_ack 2 cycles after release -> mem_req=0 during reset, no valid pulse, state IDLE.
REQ-042 Cache (SPR_ROM_CACHE_EN): fetch 0x40, then rnd_req 0x40 -> second rnd_valid 2 cycles later, same data, mem_req stays 0; without the macro -> second mem_req issued.
REQ-043 Simultaneous rnd_req and cpu_req in IDLE, fair_cnt=0 -> renderer served first, CPU served next, cpu_valid after rnd_valid.

Source files
------------

// File: rtl/spr_rom_arbiter.sv
// spr_rom_arbiter: shares one sprite ROM port between renderer and CPU.
// Define SPR_ROM_CACHE_EN to add a one-entry renderer read cache.
module spr_rom_arbiter #(
    parameter int AW       = 19,
    parameter int FAIR_MAX = 4
) (
    input  logic          clk_main,
    input  logic          reset,
    input  logic          rnd_req,
    input  logic [AW-1:0] rnd_addr,
    output logic          rnd_valid,
    output logic [31:0]   rnd_data,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_valid,
    output logic [31:0]   cpu_data,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [31:0]   mem_dout,
    output logic          overrun
);

    localparam int FW = $clog2(FAIR_MAX + 1);
    localparam logic [FW-1:0] FAIR_TOP = FW'(FAIR_MAX);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic          rnd_pend_q, rnd_pend_d;
    logic [AW-1:0] rnd_addr_q, rnd_addr_d;
    logic          cpu_pend_q, cpu_pend_d;
    logic [AW-1:0] cpu_addr_q, cpu_addr_d;
    logic [FW-1:0] fair_cnt_q, fair_cnt_d;
    logic          overrun_q, overrun_d;
    logic          owner_q, owner_d;
    logic          mem_req_q, mem_req_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          rnd_valid_q, rnd_valid_d;
    logic          cpu_valid_q, cpu_valid_d;
    logic [31:0]   rnd_data_q, rnd_data_d;
    logic [31:0]   cpu_data_q, cpu_data_d;

    logic          rnd_grant;
    logic          cpu_grant;
    logic          rnd_hit;
    logic          mem_go;
    logic          ack_take;
    logic          cache_hit;
    logic [31:0]   hit_data;

    // An ack only counts while a transaction is outstanding.
    assign ack_take = (state_q == ISSUE) && mem_ack;

`ifdef SPR_ROM_CACHE_EN
    logic          cache_vld_q;
    logic [AW-1:0] cache_tag_q;
    logic [31:0]   cache_data_q;

    assign cache_hit = cache_vld_q && (rnd_addr_q == cache_tag_q);
    assign hit_data  = cache_data_q;

    // Remember the most recent renderer fill; CPU fills leave it alone.
    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            cache_vld_q  <= 1'b0;
            cache_tag_q  <= '0;
            cache_data_q <= '0;
        end else if (ack_take && !owner_q) begin
            cache_vld_q  <= 1'b1;
            cache_tag_q  <= mem_addr_q;
            cache_data_q <= mem_dout;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_data  = '0;
`endif

    // Arbitration, slot bookkeeping and next-state decode.
    always_comb begin
        state_d   = state_q;
        rnd_grant = 1'b0;
        cpu_grant = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cpu_pend_q &&
                    (!rnd_pend_q || fair_cnt_q == FAIR_TOP)) begin
                    cpu_grant = 1'b1;
                    state_d   = ISSUE;
                end else if (rnd_pend_q) begin
                    rnd_grant = 1'b1;
                    if (!cache_hit) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rnd_hit = rnd_grant && cache_hit;
        mem_go  = cpu_grant || (rnd_grant && !cache_hit);

        rnd_pend_d = rnd_req || (rnd_pend_q && !rnd_grant);
        rnd_addr_d = rnd_req ? rnd_addr : rnd_addr_q;
        cpu_pend_d = cpu_req || (cpu_pend_q && !cpu_grant);
        cpu_addr_d = cpu_req ? cpu_addr : cpu_addr_q;

        // A strobe on the grant cycle simply re-arms the slot.
        overrun_d = overrun_q ||
                    (rnd_req && rnd_pend_q && !rnd_grant);

        fair_cnt_d = fair_cnt_q;
        if (!cpu_pend_q || cpu_grant) begin
            fair_cnt_d = '0;
        end else if (rnd_grant && fair_cnt_q != FAIR_TOP) begin
            fair_cnt_d = fair_cnt_q + 1'b1;
        end

        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        owner_d    = owner_q;
        if (mem_go) begin
            mem_req_d  = 1'b1;
            mem_addr_d = cpu_grant ? cpu_addr_q : rnd_addr_q;
            owner_d    = cpu_grant;
        end else if (ack_take) begin
            mem_req_d = 1'b0;
        end

        rnd_valid_d = (ack_take && !owner_q) || rnd_hit;
        cpu_valid_d = ack_take && owner_q;

        rnd_data_d = rnd_data_q;
        cpu_data_d = cpu_data_q;
        if (ack_take && !owner_q) begin
            rnd_data_d = mem_dout;
        end else if (rnd_hit) begin
            rnd_data_d = hit_data;
        end
        if (ack_take && owner_q) begin
            cpu_data_d = mem_dout;
        end
    end

    // Control state, request slots and memory-side registers.
    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rnd_pend_q <= 1'b0;
            rnd_addr_q <= '0;
            cpu_pend_q <= 1'b0;
            cpu_addr_q <= '0;
            fair_cnt_q <= '0;
            overrun_q  <= 1'b0;
            owner_q    <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            rnd_pend_q <= rnd_pend_d;
            rnd_addr_q <= rnd_addr_d;
            cpu_pend_q <= cpu_pend_d;
            cpu_addr_q <= cpu_addr_d;
            fair_cnt_q <= fair_cnt_d;
            overrun_q  <= overrun_d;
            owner_q    <= owner_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Return-side valid strobes and held read data.
    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            rnd_valid_q <= 1'b0;
            cpu_valid_q <= 1'b0;
            rnd_data_q  <= '0;
            cpu_data_q  <= '0;
        end else begin
            rnd_valid_q <= rnd_valid_d;
            cpu_valid_q <= cpu_valid_d;
            rnd_data_q  <= rnd_data_d;
            cpu_data_q  <= cpu_data_d;
        end
    end

    assign rnd_valid = rnd_valid_q;
    assign rnd_data  = rnd_data_q;
    assign cpu_valid = cpu_valid_q;
    assign cpu_data  = cpu_data_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_spr_rom_arbiter.sv
// tb_spr_rom_arbiter: directed vectors and corner sequences.
// Memory returns {8'hC0, 5'b0, addr} unless a fixed word is set.
module tb_spr_rom_arbiter;

    logic        clk_main = 1'b0;
    logic        reset    = 1'b1;
    logic        rnd_req  = 1'b0;
    logic [18:0] rnd_addr = '0;
    logic        rnd_valid;
    logic [31:0] rnd_data;
    logic        cpu_req  = 1'b0;
    logic [18:0] cpu_addr = '0;
    logic        cpu_valid;
    logic [31:0] cpu_data;
    logic        mem_req;
    logic [18:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_dout;
    logic        overrun;

    logic        ack_auto  = 1'b0;
    logic [31:0] dout_auto = '0;
    logic        ack_man   = 1'b0;
    logic [31:0] dout_man  = '0;

    assign mem_ack  = ack_auto | ack_man;
    assign mem_dout = ack_man ? dout_man : dout_auto;

    spr_rom_arbiter #(.AW(19), .FAIR_MAX(4)) dut (
        .clk_main  (clk_main),
        .reset     (reset),
        .rnd_req   (rnd_req),
        .rnd_addr  (rnd_addr),
        .rnd_valid (rnd_valid),
        .rnd_data  (rnd_data),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_valid (cpu_valid),
        .cpu_data  (cpu_data),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_dout  (mem_dout),
        .overrun   (overrun)
    );

    always #5 clk_main = ~clk_main;

    int total = 0;
    int bad   = 0;

    // memory model knobs (written by the main process only)
    int          ack_dly = 0;
    bit          mem_en  = 1'b1;
    bit          fix_en  = 1'b0;
    logic [31:0] fix_val = '0;
    int          wait_cnt = 0;

    // Memory responder: ack ack_dly cycles after mem_req is seen.
    always begin
        @(posedge clk_main);
        #1;
        ack_auto = 1'b0;
        if (mem_en && mem_req) begin
            if (wait_cnt >= ack_dly) begin
                ack_auto  = 1'b1;
                dout_auto = fix_en ? fix_val : {8'hC0, 5'b0, mem_addr};
                wait_cnt  = 0;
            end else begin
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Protocol watchers.
    logic        prev_req  = 1'b0;
    logic        prev_ack  = 1'b0;
    logic [18:0] prev_addr = '0;
    int          v_both = 0;
    int          v_drop = 0;
    int          v_addr = 0;

    always @(negedge clk_main) begin
        if (reset) begin
            prev_req <= 1'b0;
            prev_ack <= 1'b0;
        end else begin
            if (rnd_valid && cpu_valid) v_both <= v_both + 1;
            if (prev_req && !mem_req && !prev_ack) v_drop <= v_drop + 1;
            if (prev_req && mem_req && mem_addr != prev_addr)
                v_addr <= v_addr + 1;
            prev_req  <= mem_req;
            prev_ack  <= mem_ack;
            prev_addr <= mem_addr;
        end
    end

    task automatic tick();
        @(posedge clk_main);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          is_cpu;
        logic [18:0] addr;
        int          dly;
        bit          fix_en;
        logic [31:0] fix;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vt [6];

    int          req_t, v_t, v2_t, n_own, n_oth, n_r, n_c, n10, n20;
    int          r_t, c_t;
    logic [18:0] got_addr;
    logic [31:0] got_data, got2, c_data, fair_seen;
    bit          own, oth, was_req;

    initial begin
        vt[0] = '{1'b0, 19'h12345, 3, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 6};
        vt[1] = '{1'b0, 19'h00010, 0, 1'b0, 32'h0, 32'hC0000010, 3};
        vt[2] = '{1'b1, 19'h7FFFF, 1, 1'b0, 32'h0, 32'hC007FFFF, 4};
        vt[3] = '{1'b1, 19'h00000, 2, 1'b0, 32'h0, 32'hC0000000, 5};
        vt[4] = '{1'b0, 19'h40000, 5, 1'b0, 32'h0, 32'hC0040000, 8};
        vt[5] = '{1'b0, 19'h3ABCD, 2, 1'b0, 32'h0, 32'hC003ABCD, 5};

        // reset state
        tick();
        tick();
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_addr", {13'b0, mem_addr}, 32'd0);
        chk("rst_rnd_valid", {31'b0, rnd_valid}, 32'd0);
        chk("rst_cpu_valid", {31'b0, cpu_valid}, 32'd0);
        chk("rst_rnd_data", rnd_data, 32'd0);
        chk("rst_cpu_data", cpu_data, 32'd0);
        chk("rst_overrun", {31'b0, overrun}, 32'd0);
        reset = 1'b0;
        tick();

        // single uncached transactions
        for (int i = 0; i < 6; i++) begin
            ack_dly = vt[i].dly;
            fix_en  = vt[i].fix_en;
            fix_val = vt[i].fix;
            if (vt[i].is_cpu) begin
                cpu_req = 1'b1;
                cpu_addr = vt[i].addr;
            end else begin
                rnd_req = 1'b1;
                rnd_addr = vt[i].addr;
            end
            req_t = -1; v_t = -1; n_own = 0; n_oth = 0;
            got_addr = '0; got_data = '0;
            for (int t = 1; t <= 14; t++) begin
                tick();
                rnd_req = 1'b0;
                cpu_req = 1'b0;
                if (mem_req && req_t < 0) begin
                    req_t = t;
                    got_addr = mem_addr;
                end
                own = vt[i].is_cpu ? cpu_valid : rnd_valid;
                oth = vt[i].is_cpu ? rnd_valid : cpu_valid;
                if (own) begin
                    n_own = n_own + 1;
                    v_t = t;
                    got_data = vt[i].is_cpu ? cpu_data : rnd_data;
                end
                if (oth) n_oth = n_oth + 1;
            end
            chk($sformatf("v%0d_req_cycle", i), req_t, 32'd2);
            chk($sformatf("v%0d_mem_addr", i), {13'b0, got_addr},
                {13'b0, vt[i].addr});
            chk($sformatf("v%0d_valid_count", i), n_own, 32'd1);
            chk($sformatf("v%0d_valid_cycle", i), v_t, vt[i].exp_lat);
            chk($sformatf("v%0d_data", i), got_data, vt[i].exp_data);
            chk($sformatf("v%0d_other_valid", i), n_oth, 32'd0);
        end
        fix_en = 1'b0;

        // simultaneous requests: renderer first, CPU next
        ack_dly = 1;
        rnd_req = 1'b1; rnd_addr = 19'h00100;
        cpu_req = 1'b1; cpu_addr = 19'h00200;
        r_t = -1; c_t = -1; got_data = '0; c_data = '0;
        for (int t = 1; t <= 14; t++) begin
            tick();
            rnd_req = 1'b0;
            cpu_req = 1'b0;
            if (rnd_valid) begin r_t = t; got_data = rnd_data; end
            if (cpu_valid) begin c_t = t; c_data = cpu_data; end
        end
        chk("simul_rnd_cycle", r_t, 32'd4);
        chk("simul_rnd_data", got_data, 32'hC0000100);
        chk("simul_cpu_cycle", c_t, 32'd8);
        chk("simul_cpu_data", c_data, 32'hC0000200);

        // strobe on the grant cycle re-arms without overrun
        ack_dly = 0;
        rnd_req = 1'b1; rnd_addr = 19'h00500;
        v_t = -1; v2_t = -1; got_data = '0; got2 = '0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            rnd_req = (t == 1);
            if (t == 1) rnd_addr = 19'h00600;
            if (rnd_valid) begin
                if (v_t < 0) begin v_t = t; got_data = rnd_data; end
                else begin v2_t = t; got2 = rnd_data; end
            end
        end
        chk("rearm_first_cycle", v_t, 32'd3);
        chk("rearm_first_data", got_data, 32'hC0000500);
        chk("rearm_second_cycle", v2_t, 32'd6);
        chk("rearm_second_data", got2, 32'hC0000600);
        chk("rearm_no_overrun", {31'b0, overrun}, 32'd0);

        // fairness: CPU waits behind exactly FAIR_MAX renderer grants
        ack_dly = 0;
        cpu_req = 1'b1; cpu_addr = 19'h00700;
        rnd_req = 1'b1; rnd_addr = 19'h00800;
        n_r = 0; n_c = 0; r_t = 0; c_t = -1;
        c_data = '0; fair_seen = 32'hFFFF_FFFF; got_data = 32'hFFFF_FFFF;
        for (int t = 1; t <= 30; t++) begin
            tick();
            rnd_req = 1'b0;
            cpu_req = 1'b0;
            if (t == 12) got_data = {29'b0, dut.fair_cnt_q};
            if (rnd_valid) begin
                n_r = n_r + 1;
                if (n_c == 0) begin
                    r_t = n_r;
                    rnd_req = 1'b1;
                    rnd_addr = 19'h00800 + 19'(n_r);
                end
            end
            if (cpu_valid) begin
                n_c = n_c + 1;
                c_t = t;
                c_data = cpu_data;
                fair_seen = {29'b0, dut.fair_cnt_q};
            end
        end
        chk("fair_cnt_at_max", got_data, 32'd4);
        chk("fair_rnd_before_cpu", r_t, 32'd4);
        chk("fair_cpu_count", n_c, 32'd1);
        chk("fair_cpu_cycle", c_t, 32'd15);
        chk("fair_cpu_data", c_data, 32'hC0000700);
        chk("fair_cnt_cleared", fair_seen, 32'd0);
        chk("fair_rnd_total", n_r, 32'd5);

        // overrun: two renderer strobes behind a CPU fetch
        ack_dly = 4;
        cpu_req = 1'b1; cpu_addr = 19'h00300;
        n10 = 0; n20 = 0; n_r = 0; n_c = 0; r_t = -1; c_t = -1;
        got_data = '0; c_data = '0; was_req = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            cpu_req = 1'b0;
            rnd_req = (t == 2) || (t == 4);
            if (t == 2) rnd_addr = 19'h00010;
            if (t == 4) rnd_addr = 19'h00020;
            if (t == 3) chk("ovr_before", {31'b0, overrun}, 32'd0);
            if (t == 5) chk("ovr_after", {31'b0, overrun}, 32'd1);
            if (mem_req && mem_addr == 19'h00010) n10 = n10 + 1;
            if (mem_req && !was_req && mem_addr == 19'h00020)
                n20 = n20 + 1;
            was_req = mem_req;
            if (rnd_valid) begin
                n_r = n_r + 1; r_t = t; got_data = rnd_data;
            end
            if (cpu_valid) begin
                n_c = n_c + 1; c_t = t; c_data = cpu_data;
            end
        end
        rnd_req = 1'b0;
        chk("ovr_cpu_cycle", c_t, 32'd7);
        chk("ovr_cpu_data", c_data, 32'hC0000300);
        chk("ovr_no_fetch_10", n10, 32'd0);
        chk("ovr_fetch_20", n20, 32'd1);
        chk("ovr_rnd_count", n_r, 32'd1);
        chk("ovr_rnd_cycle", r_t, 32'd14);
        chk("ovr_rnd_data", got_data, 32'hC0000020);
        chk("ovr_sticky", {31'b0, overrun}, 32'd1);

        // reset in the middle of ISSUE, then a stray ack
        mem_en = 1'b0;
        rnd_req = 1'b1; rnd_addr = 19'h00900;
        tick();
        rnd_req = 1'b0;
        tick();
        chk("rmid_req_up", {31'b0, mem_req}, 32'd1);
        tick();
        reset = 1'b1;
        #1;
        chk("rmid_req_in_reset", {31'b0, mem_req}, 32'd0);
        chk("rmid_ovr_in_reset", {31'b0, overrun}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        n_r = 0; n_c = 0; n10 = 0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            ack_man = (t == 2);
            dout_man = 32'h11111111;
            if (rnd_valid) n_r = n_r + 1;
            if (cpu_valid) n_c = n_c + 1;
            if (mem_req) n10 = n10 + 1;
        end
        ack_man = 1'b0;
        chk("rmid_no_rnd_valid", n_r, 32'd0);
        chk("rmid_no_cpu_valid", n_c, 32'd0);
        chk("rmid_no_mem_req", n10, 32'd0);
        chk("rmid_state_idle", {30'b0, dut.state_q}, 32'd0);
        chk("rmid_rnd_data", rnd_data, 32'd0);
        mem_en = 1'b1;
        tick();

        // repeat fetch of one address: cache hit or second fill
        ack_dly = 1;
        rnd_req = 1'b1; rnd_addr = 19'h00040;
        v_t = -1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            rnd_req = 1'b0;
            if (rnd_valid) v_t = t;
        end
        chk("rep_first_cycle", v_t, 32'd4);
        rnd_req = 1'b1; rnd_addr = 19'h00040;
        v_t = -1; req_t = -1; n10 = 0; n_r = 0; got_data = '0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            rnd_req = 1'b0;
            if (mem_req) begin
                n10 = n10 + 1;
                if (req_t < 0) req_t = t;
            end
            if (rnd_valid) begin
                n_r = n_r + 1; v_t = t; got_data = rnd_data;
            end
        end
        chk("rep_valid_count", n_r, 32'd1);
        chk("rep_data", got_data, 32'hC0000040);
`ifdef SPR_ROM_CACHE_EN
        chk("rep_hit_cycle", v_t, 32'd2);
        chk("rep_hit_no_mem", n10, 32'd0);
`else
        chk("rep_miss_cycle", v_t, 32'd4);
        chk("rep_miss_req_cycle", req_t, 32'd2);
`endif

        tick();
        chk("inv_valid_overlap", v_both, 32'd0);
        chk("inv_req_drop", v_drop, 32'd0);
        chk("inv_addr_change", v_addr, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
